// File: rtl/uart_loopback_top.sv
// Self-contained UART loopback block: a free-running bit/sample clock generator,
// a single-shot transmitter that sends TX_DATA once after reset, and an
// oversampling receiver that presents the last good byte on datareg/rxOut.
// Everything runs from clk; txclk and rxclk are outputs only, never clocks.

module uart_loopback_top #(
    parameter int         BIT_CYCLES = 64,
    parameter int         OVERSAMPLE = 8,
    parameter logic [7:0] TX_DATA    = 8'h33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rxclk,
    output logic       txclk,
    output logic       txd,
    input  logic       rxd,
    output logic       rxOut,
    output logic [7:0] datareg
);

    localparam int SAMPLE_CYCLES = BIT_CYCLES / OVERSAMPLE;
    localparam int TXW           = $clog2(BIT_CYCLES);
    localparam int RXW           = $clog2(SAMPLE_CYCLES);
    localparam int SW            = $clog2(OVERSAMPLE);

    localparam logic [TXW-1:0] TX_LAST = TXW'(BIT_CYCLES - 1);
    localparam logic [TXW-1:0] TX_HALF = TXW'(BIT_CYCLES / 2 - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(SAMPLE_CYCLES - 1);
    localparam logic [RXW-1:0] RX_HALF = RXW'(SAMPLE_CYCLES / 2 - 1);
    localparam logic [SW-1:0]  MID_S   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]  LAST_S  = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [TXW-1:0] tx_cnt;
    logic [RXW-1:0] rx_cnt;
    logic           tx_tick;
    logic           rx_tick;

    state_t         tx_state;
    logic [2:0]     tx_bit;
    logic           tx_sent;

    logic           rxd_meta;
    logic           rxd_sync;
    state_t         rx_state;
    logic [2:0]     rx_bit;
    logic [SW-1:0]  sample_cnt;
    logic [7:0]     shift_reg;

    // The ticks fire on the cycle whose edge raises the matching square wave,
    // so the FSMs step in lockstep with the visible txclk/rxclk rising edges.
    assign tx_tick = (tx_cnt == TX_HALF);
    assign rx_tick = (rx_cnt == RX_HALF);

    // Bit-rate counter and 50%-duty txclk: low for the first half of the count, high for the second.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values; = here would chain registers within one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt <= '0;
            txclk  <= 1'b0;
        end else if (tx_cnt == TX_LAST) begin
            tx_cnt <= '0;
            txclk  <= 1'b0;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
            if (tx_cnt == TX_HALF) begin
                txclk <= 1'b1;
            end
        end
    end

    // Sample-rate counter and 50%-duty rxclk, same shape as the bit clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt <= '0;
            rxclk  <= 1'b0;
        end else if (rx_cnt == RX_LAST) begin
            rx_cnt <= '0;
            rxclk  <= 1'b0;
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == RX_HALF) begin
                rxclk <= 1'b1;
            end
        end
    end

    // Single-shot transmitter; txd is registered and changes only on tx_tick.
    // NOTE: every control register here has an explicit reset value; there are no storage arrays, so nothing is left to power-up state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_bit   <= 3'd0;
            tx_sent  <= 1'b0;
            txd      <= 1'b1;
        end else if (tx_tick) begin
            case (tx_state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!tx_sent) begin
                        tx_state <= START;
                        txd      <= 1'b0;
                    end
                end
                START: begin
                    tx_state <= DATA;
                    tx_bit   <= 3'd0;
                    txd      <= TX_DATA[0];
                end
                DATA: begin
                    if (tx_bit == 3'd7) begin
                        tx_state <= STOP;
                        txd      <= 1'b1;
                    end else begin
                        tx_bit <= tx_bit + 3'd1;
                        txd    <= TX_DATA[tx_bit + 3'd1];
                    end
                end
                STOP: begin
                    tx_state <= IDLE;
                    tx_sent  <= 1'b1;
                    txd      <= 1'b1;
                end
                default: begin
                    tx_state <= IDLE;
                    txd      <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous serial input; resets to the idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Oversampling receiver: confirm the start bit at mid-bit, then sample each
    // following bit one full bit later, and commit only on a high stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= IDLE;
            rx_bit     <= 3'd0;
            sample_cnt <= '0;
            shift_reg  <= 8'h00;
            datareg    <= 8'h00;
            rxOut      <= 1'b0;
        end else if (rx_tick) begin
            case (rx_state)
                IDLE: begin
                    if (!rxd_sync) begin
                        rx_state   <= START;
                        sample_cnt <= '0;
                    end
                end
                START: begin
                    if (sample_cnt == MID_S) begin
                        if (rxd_sync) begin
                            rx_state <= IDLE;
                        end else begin
                            rxOut      <= 1'b0;
                            rx_state   <= DATA;
                            rx_bit     <= 3'd0;
                            sample_cnt <= '0;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_cnt == LAST_S) begin
                        sample_cnt <= '0;
                        shift_reg  <= {rxd_sync, shift_reg[7:1]};
                        rx_bit     <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= STOP;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (sample_cnt == LAST_S) begin
                        sample_cnt <= '0;
                        rx_state   <= IDLE;
                        if (rxd_sync) begin
                            datareg <= shift_reg;
                            rxOut   <= 1'b1;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                default: begin
                    rx_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loopback_top.sv
// Directed bench for uart_loopback_top: reset values, clock shapes, the
// single-shot loopback frame, a table of externally driven frames (good and
// framing-error), rxd glitches, and a reset in the middle of a transmission.
`timescale 1ns/1ps

module tb_uart_loopback_top;

    localparam int BITC = 64;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       rxclk;
    logic       txclk;
    logic       txd;
    logic       rxd;
    logic       rxOut;
    logic [7:0] datareg;

    logic       loop_en = 1'b1;
    logic       rxd_ext = 1'b1;
    logic       txd_d   = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [8];

    // Expected line levels of the 0x33 frame, index 0 = start bit.
    logic [9:0] exp_frame = 10'b1001100110;

    uart_loopback_top dut (
        .clk     (clk),
        .rst     (rst),
        .rxclk   (rxclk),
        .txclk   (txclk),
        .txd     (txd),
        .rxd     (rxd),
        .rxOut   (rxOut),
        .datareg (datareg)
    );

    always #5 clk = ~clk;

    // Loopback path registers txd once, as an external flop would.
    always @(posedge clk) txd_d <= txd;
    assign rxd = loop_en ? txd_d : rxd_ext;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
    endtask

    // Finds the start bit, checks its width and the mid-bit level of every later bit.
    task automatic capture_frame(input string tag);
        int n;
        int len;
        n = 0;
        while (txd !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, 32'(txd), 32'(exp_frame[0]));
        if (txd === 1'b0) begin
            len = 0;
            while (txd === 1'b0 && len < 200) begin
                @(negedge clk);
                len++;
            end
            check({tag, "_start_len"}, 32'(len), 32'(BITC));
            repeat (BITC / 2) @(negedge clk);
            for (int k = 1; k < 10; k++) begin
                check($sformatf("%s_bit%0d", tag, k), 32'(txd), 32'(exp_frame[k]));
                repeat (BITC) @(negedge clk);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic s);
        @(negedge clk);
        rxd_ext = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_ext = d[i];
            repeat (BITC) @(negedge clk);
        end
        rxd_ext = s;
        repeat (BITC) @(negedge clk);
        rxd_ext = 1'b1;
        repeat (3 * BITC) @(negedge clk);
    endtask

    initial begin
        int cyc, tx_rises, rx_rises, bad_period, bad_duty;
        int last_tx, last_rx, hi_tx, hi_rx;
        int bad_txd, bad_data, bad_valid;
        logic prev_tx, prev_rx;

        vecs[0] = '{8'hA5, 1'b0, 8'h33, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 8'h3C, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b1};
        vecs[6] = '{8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'h01, 1'b1, 8'h01, 1'b1};

        // Reset values while rst is held low.
        repeat (5) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_rxOut", 32'(rxOut), 32'd0);
        check("rst_datareg", 32'(datareg), 32'h00);
        check("rst_rxclk", 32'(rxclk), 32'd0);
        check("rst_txclk", 32'(txclk), 32'd0);

        // Clock shapes over 1000 cycles after release.
        rst = 1'b1;
        cyc = 0; tx_rises = 0; rx_rises = 0; bad_period = 0; bad_duty = 0;
        last_tx = -1; last_rx = -1; hi_tx = -1; hi_rx = -1;
        prev_tx = txclk; prev_rx = rxclk;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cyc++;
            if (txclk && !prev_tx) begin
                tx_rises++;
                if (last_tx >= 0 && cyc - last_tx != 64) bad_period++;
                last_tx = cyc; hi_tx = cyc;
            end
            if (!txclk && prev_tx && hi_tx >= 0 && cyc - hi_tx != 32) bad_duty++;
            if (rxclk && !prev_rx) begin
                rx_rises++;
                if (last_rx >= 0 && cyc - last_rx != 8) bad_period++;
                last_rx = cyc; hi_rx = cyc;
            end
            if (!rxclk && prev_rx && hi_rx >= 0 && cyc - hi_rx != 4) bad_duty++;
            prev_tx = txclk; prev_rx = rxclk;
        end
        check("clk_period_errors", 32'(bad_period), 32'd0);
        check("clk_duty_errors", 32'(bad_duty), 32'd0);
        check("txclk_rises", 32'(tx_rises >= 15), 32'd1);
        check("clk_ratio_8_1", 32'(rx_rises >= 8 * tx_rises - 8 && rx_rises <= 8 * tx_rises + 8), 32'd1);

        // Loopback of the single 0x33 frame.
        loop_en = 1'b1;
        apply_reset();
        capture_frame("loop");
        repeat (1300) @(negedge clk);
        check("loop_datareg", 32'(datareg), 32'h33);
        check("loop_rxOut", 32'(rxOut), 32'd1);

        // No second transmission; received byte holds for 50 us.
        bad_txd = 0; bad_data = 0; bad_valid = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad_txd++;
            if (datareg !== 8'h33) bad_data++;
            if (rxOut !== 1'b1) bad_valid++;
        end
        check("single_shot_txd_idle", 32'(bad_txd), 32'd0);
        check("hold_datareg", 32'(bad_data), 32'd0);
        check("hold_rxOut", 32'(bad_valid), 32'd0);

        // Externally driven frames, including framing errors.
        loop_en = 1'b0;
        rxd_ext = 1'b1;
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            check($sformatf("vec%0d_datareg", v), 32'(datareg), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_rxOut", v), 32'(rxOut), 32'(vecs[v].exp_valid));
        end

        // One-cycle low glitches at several phases must not disturb the result.
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            rxd_ext = 1'b0;
            @(negedge clk);
            rxd_ext = 1'b1;
            repeat (100 + p) @(negedge clk);
        end
        repeat (2 * BITC) @(negedge clk);
        check("glitch_datareg", 32'(datareg), 32'h01);
        check("glitch_rxOut", 32'(rxOut), 32'd1);

        // Reset in the middle of the transmitter's DATA phase (bit 2, line low).
        loop_en = 1'b1;
        apply_reset();
        cyc = 0;
        while (txd !== 1'b0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4 * BITC - BITC / 2) @(negedge clk);
        check("midrst_pre_txd", 32'(txd), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_rxOut", 32'(rxOut), 32'd0);
        check("midrst_datareg", 32'(datareg), 32'h00);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        capture_frame("resend");
        repeat (1300) @(negedge clk);
        check("resend_datareg", 32'(datareg), 32'h33);
        check("resend_rxOut", 32'(rxOut), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
